// File: rtl/reg_dump_sequencer.sv
// reg_dump_sequencer: after program end, sweeps the register file debug port and streams each value over valid/ready with a rotating-XOR checksum
module reg_dump_sequencer #(
  parameter int ADDR_W    = 16,
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 31,
  parameter int SETTLE    = 1
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              Enable,
  input  logic [ADDR_W-1:0] InstrAddr,
  input  logic [ADDR_W-1:0] InstrCount,
  output logic [4:0]        RegAddr,
  input  logic [31:0]       RegData,
  output logic              DumpValid,
  input  logic              DumpReady,
  output logic [4:0]        DumpIdx,
  output logic [31:0]       DumpData,
  output logic [31:0]       Checksum,
  output logic              Busy,
  output logic              Halted,
  output logic              Done
);
  typedef enum logic [2:0] {IDLE, ARMED, DRIVE, OUT, DONE} state_t;
  localparam int CW = $clog2(SETTLE + 1) + 1;
  localparam logic [4:0] FIRST = 5'(FIRST_REG);
  localparam logic [4:0] LAST = 5'(LAST_REG);
  localparam logic [CW-1:0] SET = CW'(SETTLE);
  state_t state;
  logic [CW-1:0] cnt;
  assign Busy = (state == ARMED) || (state == DRIVE) || (state == OUT);
  assign Done = state == DONE;
  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) begin
      state     <= IDLE;
      cnt       <= '0;
      RegAddr   <= '0;
      DumpValid <= 1'b0;
      DumpIdx   <= '0;
      DumpData  <= '0;
      Checksum  <= '0;
      Halted    <= 1'b0;
    end else if (state != IDLE && !Enable) begin
      state     <= IDLE;
      DumpValid <= 1'b0;
    end else
      case (state)
        IDLE:
          if (Enable) begin
            state    <= ARMED;
            Checksum <= '0;
            Halted   <= 1'b0;
          end
        ARMED:
          if ((InstrAddr >> 2) == InstrCount) begin
            state   <= DRIVE;
            Halted  <= 1'b1;
            RegAddr <= FIRST;
            cnt     <= SET;
          end
        DRIVE: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state     <= OUT;
            DumpData  <= RegData;
            DumpIdx   <= RegAddr;
            DumpValid <= 1'b1;
          end
        end
        OUT:
          if (DumpReady) begin
            Checksum  <= {Checksum[30:0], Checksum[31]} ^ DumpData;
            DumpValid <= 1'b0;
            if (RegAddr == LAST) state <= DONE;
            else begin
              state   <= DRIVE;
              RegAddr <= RegAddr + 1'b1;
              cnt     <= SET;
            end
          end
        default: state <= IDLE;
      endcase
endmodule
